// File: rtl/icache_axi4_rd_bridge_if.sv
// AXI4 read-address / read-data channel bundle for the icache refill bridge.
// The master modport is the bridge side; the slave modport is the interconnect side.
interface icache_axi4_rd_bridge_if #(
  parameter int ID_WIDTH = 4
);
  logic                arvalid;
  logic                arready;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [ID_WIDTH-1:0] arid;
  logic                rvalid;
  logic                rready;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [ID_WIDTH-1:0] rid;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/icache_axi4_rd_bridge.sv
// Icache refill port to AXI4 INCR read burst bridge with flush draining and a one-entry pending request.
// Optional beat/rlast protocol checker enabled by defining ICACHE_AXI_BRIDGE_CHECK_EN.
module icache_axi4_rd_bridge #(
  parameter int                  ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID   = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  mem_len_i,
  input  logic        up_flush_i,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_rlast_o,
  output logic        mem_err_o,
  output logic        proto_err_o,
  icache_axi4_rd_bridge_if.master axi
);

  typedef enum logic [1:0] {IDLE, AR, R, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic        drop_q, drop_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [7:0]  pend_len_q, pend_len_d;
  logic        mem_rvalid_q, mem_rlast_q, mem_err_q;
  logic [31:0] mem_rdata_q;

  logic rready, beat, fwd, burst_end, ar_hs;

  assign rready    = (state_q == R) || (state_q == DRAIN);
  assign beat      = axi.rvalid && rready;
  assign burst_end = beat && axi.rlast;
  assign ar_hs     = (state_q == AR) && axi.arready;
  // A beat that coincides with a flush is swallowed, not forwarded.
  assign fwd       = (state_q == R) && beat && !up_flush_i;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    drop_d      = drop_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_len_d  = pend_len_q;

    // A new request always wins over a flush in the same cycle.
    if (state_q != IDLE) begin
      if (mem_req_i) begin
        pend_vld_d  = 1'b1;
        pend_addr_d = mem_addr_i;
        pend_len_d  = mem_len_i;
      end else if (up_flush_i) begin
        pend_vld_d = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: if (mem_req_i) begin
        araddr_d = mem_addr_i;
        arlen_d  = mem_len_i;
        state_d  = AR;
      end
      AR: begin
        if (up_flush_i) drop_d = 1'b1;
        if (axi.arready) state_d = (drop_q || up_flush_i) ? DRAIN : R;
      end
      R:       if (up_flush_i) state_d = DRAIN;
      DRAIN:   ;
      default: state_d = IDLE;
    endcase

    // End of the outstanding burst: chain straight into the pended request if there is one.
    if (burst_end) begin
      drop_d = 1'b0;
      if (pend_vld_d) begin
        araddr_d   = pend_addr_d;
        arlen_d    = pend_len_d;
        pend_vld_d = 1'b0;
        state_d    = AR;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      araddr_q     <= '0;
      arlen_q      <= '0;
      drop_q       <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_addr_q  <= '0;
      pend_len_q   <= '0;
      mem_rvalid_q <= 1'b0;
      mem_rdata_q  <= '0;
      mem_rlast_q  <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      drop_q       <= drop_d;
      pend_vld_q   <= pend_vld_d;
      pend_addr_q  <= pend_addr_d;
      pend_len_q   <= pend_len_d;
      mem_rvalid_q <= fwd;
      mem_rlast_q  <= fwd && axi.rlast;
      mem_err_q    <= fwd && (axi.rresp != 2'b00);
      if (fwd) mem_rdata_q <= axi.rdata;
    end
  end

  assign axi.arvalid  = (state_q == AR);
  assign axi.araddr   = araddr_q;
  assign axi.arlen    = arlen_q;
  assign axi.arsize   = 3'b010;
  assign axi.arburst  = 2'b01;
  assign axi.arid     = AXI_ID;
  assign axi.rready   = rready;

  assign mem_rvalid_o = mem_rvalid_q;
  assign mem_rdata_o  = mem_rdata_q;
  assign mem_rlast_o  = mem_rlast_q;
  assign mem_err_o    = mem_err_q;

`ifdef ICACHE_AXI_BRIDGE_CHECK_EN
  logic [7:0] beat_cnt_q;
  logic       proto_err_q;
  logic       proto_set;

  // Beat index must reach arlen exactly on the rlast beat; R data outside a burst is illegal.
  assign proto_set = (beat && ( axi.rlast && (beat_cnt_q != arlen_q))) ||
                     (beat && (!axi.rlast && (beat_cnt_q == arlen_q))) ||
                     (axi.rvalid && ((state_q == IDLE) || (state_q == AR)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (ar_hs)     beat_cnt_q <= '0;
      else if (beat) beat_cnt_q <= beat_cnt_q + 8'd1;
      if (proto_set) proto_err_q <= 1'b1;
    end
  end

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!rst && proto_set && !proto_err_q)
      $display("icache_axi4_rd_bridge: AXI R protocol error at beat %0d (arlen %0d)", beat_cnt_q, arlen_q);
  end
`endif

  assign proto_err_o = proto_err_q;
`else
  logic unused_hs;
  assign unused_hs   = ar_hs;
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_icache_axi4_rd_bridge.sv
// Self-checking bench for icache_axi4_rd_bridge: directed cases plus randomized bursts
// checked against a transaction-level model of which beats must reach the cache and when.
module tb_icache_axi4_rd_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_len;
  logic        up_flush;
  logic        mem_rvalid_o, mem_rlast_o, mem_err_o, proto_err_o;
  logic [31:0] mem_rdata_o;

  icache_axi4_rd_bridge_if #(.ID_WIDTH(4)) axi_if ();

  icache_axi4_rd_bridge #(.ID_WIDTH(4), .AXI_ID(4'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req_i    (mem_req),
    .mem_addr_i   (mem_addr),
    .mem_len_i    (mem_len),
    .up_flush_i   (up_flush),
    .mem_rvalid_o (mem_rvalid_o),
    .mem_rdata_o  (mem_rdata_o),
    .mem_rlast_o  (mem_rlast_o),
    .mem_err_o    (mem_err_o),
    .proto_err_o  (proto_err_o),
    .axi          (axi_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cache-side monitor: every expected beat must appear exactly in its cycle; nothing else may.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("beat_valid", mem_rvalid_o, 1);
        check("beat_data",  mem_rdata_o,  exp_q[0].data);
        check("beat_last",  mem_rlast_o,  exp_q[0].last);
        check("beat_err",   mem_err_o,    exp_q[0].err);
        void'(exp_q.pop_front());
      end else if (mem_rvalid_o || mem_rlast_o || mem_err_o) begin
        check("spurious_beat", {mem_rvalid_o, mem_rlast_o, mem_err_o}, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_beat(input logic [31:0] d, input logic l, input logic e);
    beat_t b;
    b.cyc = cyc + 1; b.data = d; b.last = l; b.err = e;
    exp_q.push_back(b);
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic l, input logic [1:0] resp);
    axi_if.rvalid = 1'b1;
    axi_if.rdata  = d;
    axi_if.rlast  = l;
    axi_if.rresp  = resp;
  endtask

  task automatic clear_r();
    axi_if.rvalid = 1'b0;
    axi_if.rlast  = 1'b0;
    axi_if.rresp  = 2'b00;
  endtask

  // flush_mode: 0 none, 1 during AR wait (needs ar_delay>=1), 2 with beat flush_beat.
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input int ar_delay,
                           input int flush_mode, input int flush_beat, input logic [7:0] err_mask,
                           input int max_gap, input int last_idx, input logic [31:0] dbase);
    bit dropped = 0;
    mem_req = 1'b1; mem_addr = addr; mem_len = len;
    tick();
    mem_req = 1'b0;
    check("arvalid_up", axi_if.arvalid, 1);
    check("araddr",     axi_if.araddr,  addr);
    check("arlen",      axi_if.arlen,   len);
    check("arsize",     axi_if.arsize,  3'b010);
    check("arburst",    axi_if.arburst, 2'b01);
    check("arid",       axi_if.arid,    4'h0);
    for (int c = 0; c < ar_delay; c++) begin
      if (flush_mode == 1 && c == 0) begin up_flush = 1'b1; dropped = 1; end
      tick();
      up_flush = 1'b0;
      check("arvalid_hold", axi_if.arvalid, 1);
      check("araddr_hold",  axi_if.araddr,  addr);
      check("arlen_hold",   axi_if.arlen,   len);
    end
    axi_if.arready = 1'b1;
    tick();
    axi_if.arready = 1'b0;
    check("arvalid_drop", axi_if.arvalid, 0);
    for (int i = 0; i <= last_idx; i++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) tick();
      check("rready", axi_if.rready, 1);
      drive_beat(dbase + i, i == last_idx, err_mask[i] ? 2'b10 : 2'b00);
      if (flush_mode == 2 && i == flush_beat) begin up_flush = 1'b1; dropped = 1; end
      if (!dropped) push_beat(dbase + i, i == last_idx, err_mask[i]);
      tick();
      clear_r();
      up_flush = 1'b0;
    end
    check("idle_rready",  axi_if.rready,  0);
    check("idle_arvalid", axi_if.arvalid, 0);
    tick();
    check("beats_done", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_len = '0; up_flush = 1'b0;
    axi_if.arready = 1'b0; axi_if.rdata = '0; axi_if.rid = '0;
    clear_r();
    #12;
    check("rst_arvalid",   axi_if.arvalid, 0);
    check("rst_araddr",    axi_if.araddr,  0);
    check("rst_arlen",     axi_if.arlen,   0);
    check("rst_rready",    axi_if.rready,  0);
    check("rst_mem_out",   {mem_rvalid_o, mem_rlast_o, mem_err_o}, 0);
    check("rst_mem_rdata", mem_rdata_o,    0);
    check("rst_proto_err", proto_err_o,    0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single refill, AR backpressure, flush mid-burst, error response.
    run_burst(32'h3000_0010, 8'd3, 0, 0, 0, 8'h00, 0, 3, 32'h0000_00A0);
    run_burst(32'h3000_0080, 8'd3, 5, 0, 0, 8'h00, 0, 3, 32'h0000_00B0);
    run_burst(32'h3000_0100, 8'd3, 0, 2, 1, 8'h00, 0, 3, 32'h0000_00C0);
    run_burst(32'h3000_0140, 8'd3, 1, 0, 0, 8'h04, 1, 3, 32'h0000_00D0);

    // Flush while AR waits, then a new request two cycles later lands while the old burst drains.
    mem_req = 1'b1; mem_addr = 32'h3000_0000; mem_len = 8'd3;
    tick();
    mem_req = 1'b0;
    up_flush = 1'b1;
    tick();
    up_flush = 1'b0;
    axi_if.arready = 1'b1;
    tick();
    axi_if.arready = 1'b0;
    check("drain_rready", axi_if.rready, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin mem_req = 1'b1; mem_addr = 32'h3000_0040; mem_len = 8'd1; end
      drive_beat(32'hDEAD_0000 + i, i == 3, 2'b00);
      tick();
      mem_req = 1'b0;
      clear_r();
    end
    check("rereq_arvalid", axi_if.arvalid, 1);
    check("rereq_araddr",  axi_if.araddr,  32'h3000_0040);
    check("rereq_arlen",   axi_if.arlen,   8'd1);
    axi_if.arready = 1'b1;
    tick();
    axi_if.arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_beat(32'h0000_0E00 + i, i == 1, 2'b00);
      push_beat(32'h0000_0E00 + i, i == 1, 1'b0);
      tick();
      clear_r();
    end
    check("rereq_idle", {axi_if.arvalid, axi_if.rready}, 0);
    tick();
    check("rereq_done", exp_q.size(), 0);
    exp_q.delete();

    // Randomized bursts against the beat-forwarding model.
    for (int n = 0; n < 40; n++) begin
      int          len   = $urandom_range(7, 0);
      int          ard   = $urandom_range(3, 0);
      int          fm    = $urandom_range(2, 0);
      int          fb    = 0;
      logic [31:0] addr  = $urandom & 32'hFFFF_FFC0;
      logic [7:0]  emask = 8'($urandom & $urandom);
      if (fm == 1 && ard == 0) ard = 1;
      if (fm == 2 && len == 0) fm = 0;
      if (fm == 2) fb = $urandom_range(len - 1, 0);
      run_burst(addr, 8'(len), ard, fm, fb, emask, 2, len, $urandom);
    end
    check("proto_clean", proto_err_o, 0);

    // Early rlast: beat 1 of an arlen=3 burst.
    run_burst(32'h3000_0200, 8'd3, 0, 0, 0, 8'h00, 0, 1, 32'h0000_00F0);
`ifdef ICACHE_AXI_BRIDGE_CHECK_EN
    check("proto_err_set", proto_err_o, 1);
    repeat (5) tick();
    check("proto_err_sticky", proto_err_o, 1);
`else
    check("proto_err_off", proto_err_o, 0);
    repeat (5) tick();
    check("proto_err_off2", proto_err_o, 0);
`endif
    rst = 1'b1;
    #2;
    check("proto_err_rst", proto_err_o, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
